// File: rtl/qos_pkg.sv
// Shared types and helpers for the button-driven serial word entry block.
// Holds the entry FSM state encoding and the bit-counter width rule.
package qos_pkg;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  localparam int DATA_W_DFLT = 4;
  localparam int BCNT_W      = $clog2(DATA_W_DFLT + 1);

  // Bit counter must be able to hold the value DATA_W itself.
  function automatic int bcnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Timer only ever needs to reach TIMEOUT_CYC-1; keep at least one bit.
  function automatic int timer_width(input int timeout_cyc);
    return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
  endfunction

endpackage

// File: rtl/falling_edge_det.sv
// Registers an active-low pin and flags its high-to-low transition.
// One cycle of `fall` per press, no matter how long the button is held.
module falling_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic fall
);

  logic sampled;
  logic past;

  // NOTE: non-blocking assignments so `past` takes the old `sampled`, forming a real two-stage pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      sampled <= RESET_VAL;
      past    <= RESET_VAL;
    end else begin
      sampled <= sig;
      past    <= sampled;
    end
  end

  // Asserted from the cycle the pin is first seen low until the next edge.
  assign fall = past & ~sampled;

endmodule

// File: rtl/serial_word_entry.sv
// Assembles DATA_W button-entered bits into a word and offers it on a
// valid/ready port, with inter-bit timeout, overflow drop and word counters.
module serial_word_entry
  import qos_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int CNT_W       = 12,
  parameter int MSB_FIRST   = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start_btn,
  input  logic                                high_btn,
  input  logic                                low_btn,
  output logic [DATA_W-1:0]                   out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic [bcnt_width(DATA_W)-1:0]       bit_count,
  output logic                                abort_pulse,
  output logic [CNT_W-1:0]                    received_cnt,
  output logic [CNT_W-1:0]                    dropped_cnt
);

  localparam int BC_W     = bcnt_width(DATA_W);
  localparam int TMR_W    = timer_width(TIMEOUT_CYC);
  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  state_t              state;
  logic [DATA_W-1:0]   sr;
  logic [DATA_W-1:0]   sr_next;
  logic [TMR_W-1:0]    timer;

  logic start_e;
  logic high_e;
  logic low_e;
  logic bit_e;
  logic last_bit;
  logic can_load;
  logic timed_out;

  falling_edge_det #(.RESET_VAL(1'b1)) u_start_det (
    .clock (clock),
    .reset (reset),
    .sig   (start_btn),
    .fall  (start_e)
  );

  falling_edge_det #(.RESET_VAL(1'b1)) u_high_det (
    .clock (clock),
    .reset (reset),
    .sig   (high_btn),
    .fall  (high_e)
  );

  falling_edge_det #(.RESET_VAL(1'b1)) u_low_det (
    .clock (clock),
    .reset (reset),
    .sig   (low_btn),
    .fall  (low_e)
  );

  // Simultaneous high and low presses cancel each other out.
  assign bit_e = high_e ^ low_e;

  generate
    if (DATA_W == 1) begin : g_single
      assign sr_next = high_e;
    end else if (MSB_FIRST != 0) begin : g_msb_first
      assign sr_next = {sr[DATA_W-2:0], high_e};
    end else begin : g_lsb_first
      assign sr_next = {high_e, sr[DATA_W-1:1]};
    end
  endgenerate

  assign last_bit  = (bit_count == BC_W'(DATA_W - 1));
  assign can_load  = !out_valid || out_ready;
  assign timed_out = (TIMEOUT_CYC > 0) && (timer == TMR_W'(TMO_LAST));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sr           <= '0;
      timer        <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      bit_count    <= '0;
      abort_pulse  <= 1'b0;
      received_cnt <= '0;
      dropped_cnt  <= '0;
    end else begin
      abort_pulse <= 1'b0;

      // A load later in this block overrides the handshake clear.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_e) begin
            state     <= COLLECT;
            busy      <= 1'b1;
            sr        <= '0;
            bit_count <= '0;
            timer     <= '0;
          end
        end

        COLLECT: begin
          if (start_e) begin
            sr        <= '0;
            bit_count <= '0;
            timer     <= '0;
          end else if (bit_e) begin
            timer <= '0;
            if (last_bit) begin
              state     <= IDLE;
              busy      <= 1'b0;
              bit_count <= '0;
              sr        <= sr_next;
              if (can_load) begin
                out_data     <= sr_next;
                out_valid    <= 1'b1;
                received_cnt <= received_cnt + CNT_W'(1);
              end else begin
                dropped_cnt <= dropped_cnt + CNT_W'(1);
              end
            end else begin
              sr        <= sr_next;
              bit_count <= bit_count + BC_W'(1);
            end
          end else if (timed_out) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bit_count   <= '0;
            timer       <= '0;
            abort_pulse <= 1'b1;
          end else if (TIMEOUT_CYC > 0) begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_entry.sv
// Directed bench for serial_word_entry: MSB-first instance with timeout and
// an LSB-first instance without, both driven by the same buttons.
module tb_serial_word_entry;

  logic clock = 1'b0;
  logic reset;
  logic start_btn;
  logic high_btn;
  logic low_btn;
  logic out_ready;

  logic [3:0]  a_data,  b_data;
  logic        a_valid, b_valid;
  logic        a_busy,  b_busy;
  logic [2:0]  a_bcnt,  b_bcnt;
  logic        a_abort, b_abort;
  logic [11:0] a_rcv,   b_rcv;
  logic [11:0] a_drop,  b_drop;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_word_entry #(.DATA_W(4), .CNT_W(12), .MSB_FIRST(1), .TIMEOUT_CYC(100)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .start_btn    (start_btn),
    .high_btn     (high_btn),
    .low_btn      (low_btn),
    .out_data     (a_data),
    .out_valid    (a_valid),
    .out_ready    (out_ready),
    .busy         (a_busy),
    .bit_count    (a_bcnt),
    .abort_pulse  (a_abort),
    .received_cnt (a_rcv),
    .dropped_cnt  (a_drop)
  );

  serial_word_entry #(.DATA_W(4), .CNT_W(12), .MSB_FIRST(0), .TIMEOUT_CYC(0)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .start_btn    (start_btn),
    .high_btn     (high_btn),
    .low_btn      (low_btn),
    .out_data     (b_data),
    .out_valid    (b_valid),
    .out_ready    (out_ready),
    .busy         (b_busy),
    .bit_count    (b_bcnt),
    .abort_pulse  (b_abort),
    .received_cnt (b_rcv),
    .dropped_cnt  (b_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // which: 0=start, 1=high, 2=low, 3=high+low together. Held three cycles.
  task automatic press(input int which);
    @(negedge clock);
    start_btn = (which == 0) ? 1'b0 : 1'b1;
    high_btn  = (which == 1 || which == 3) ? 1'b0 : 1'b1;
    low_btn   = (which == 2 || which == 3) ? 1'b0 : 1'b1;
    repeat (3) @(negedge clock);
    start_btn = 1'b1;
    high_btn  = 1'b1;
    low_btn   = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_ready();
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    int abort_hits;
    int abort_at;

    reset     = 1'b1;
    start_btn = 1'b1;
    high_btn  = 1'b1;
    low_btn   = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_data",  a_data,  4'h0);
    check("rst_valid", a_valid, 1'b0);
    check("rst_busy",  a_busy,  1'b0);
    check("rst_bcnt",  a_bcnt,  3'd0);
    check("rst_abort", a_abort, 1'b0);
    check("rst_rcv",   a_rcv,   12'd0);
    check("rst_drop",  a_drop,  12'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Word 1011: MSB-first gives 1011, LSB-first gives 1101.
    press(0);
    check("t1_busy", a_busy, 1'b1);
    press(1);
    press(2);
    press(1);
    check("t1_bcnt3", a_bcnt, 3'd3);
    // Final press timed by hand to observe the two-clock latency.
    @(negedge clock);
    high_btn = 1'b0;
    @(negedge clock);
    check("t1_lat_early", a_valid, 1'b0);
    @(negedge clock);
    check("t1_lat_valid", a_valid, 1'b1);
    high_btn = 1'b1;
    repeat (2) @(negedge clock);
    check("t1_data",   a_data,  4'b1011);
    check("t1_rcv",    a_rcv,   12'd1);
    check("t1_busy0",  a_busy,  1'b0);
    check("t1_bcnt0",  a_bcnt,  3'd0);
    check("t2_data_b", b_data,  4'b1101);
    check("t2_valid_b", b_valid, 1'b1);

    // Second word 0001 while the first is still unaccepted: dropped.
    press(0);
    press(2);
    press(2);
    press(2);
    press(1);
    check("t3_data",   a_data,  4'b1011);
    check("t3_valid",  a_valid, 1'b1);
    check("t3_drop",   a_drop,  12'd1);
    check("t3_rcv",    a_rcv,   12'd1);
    check("t3_drop_b", b_drop,  12'd1);
    pulse_ready();
    check("t3_accept", a_valid, 1'b0);
    check("t3_acc_b",  b_valid, 1'b0);

    // Restart discards partial; simultaneous high+low is ignored.
    press(0);
    press(1);
    press(1);
    check("t5_partial", a_bcnt, 3'd2);
    press(0);
    check("t5_restart", a_bcnt, 3'd0);
    press(2);
    press(3);
    check("t5_both", a_bcnt, 3'd1);
    check("t5_both_b", b_bcnt, 3'd1);
    press(2);
    press(2);
    press(2);
    check("t5_data",  a_data,  4'b0000);
    check("t5_valid", a_valid, 1'b1);
    check("t5_rcv",   a_rcv,   12'd2);
    check("t5_abort", a_abort, 1'b0);

    // Reset mid-word with a pending output word.
    press(0);
    press(1);
    press(2);
    press(1);
    check("t6_pre_bcnt",  a_bcnt,  3'd3);
    check("t6_pre_valid", a_valid, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_valid", a_valid, 1'b0);
    check("t6_bcnt",  a_bcnt,  3'd0);
    check("t6_busy",  a_busy,  1'b0);
    check("t6_data",  a_data,  4'h0);
    check("t6_rcv",   a_rcv,   12'd0);
    check("t6_drop",  a_drop,  12'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Timeout: abort fires 100 cycles after the last bit edge.
    press(0);
    press(1);
    check("t4_bcnt1", a_bcnt, 3'd1);
    abort_hits = 0;
    abort_at   = -1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clock);
      if (a_abort) begin
        abort_hits++;
        if (abort_at < 0) abort_at = i;
      end
    end
    check("t4_hits",  abort_hits, 1);
    check("t4_when",  abort_at,   96);
    check("t4_busy",  a_busy,     1'b0);
    check("t4_bcnt",  a_bcnt,     3'd0);
    check("t4_busy_b", b_busy,    1'b1);
    press(1);
    press(2);
    check("t4_ignored", a_bcnt, 3'd0);
    check("t4_idle",    a_busy, 1'b0);
    press(0);
    check("t4_restart", a_busy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
